// File: rtl/id_stage_pkg.sv
// uMIPS_32 shared decode constants: opcodes, function codes, ALU control
// encodings and the decoded-control bundle passed from id_ctrl to id_stage.
package uMIPS_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [4:0] REG31 = 5'd31;

  typedef enum logic [3:0] {
    ALUC_ADD = 4'b0000,
    ALUC_AND = 4'b0001,
    ALUC_XOR = 4'b0010,
    ALUC_SLL = 4'b0011,
    ALUC_SUB = 4'b0100,
    ALUC_OR  = 4'b0101,
    ALUC_LUI = 4'b0110,
    ALUC_SRL = 4'b0111,
    ALUC_SRA = 4'b1111
  } aluc_e;

  typedef enum logic [1:0] {
    IMM_SEXT = 2'd0,
    IMM_ZEXT = 2'd1,
    IMM_LUI  = 2'd2
  } immsel_e;

  typedef struct packed {
    logic    wreg;
    logic    m2reg;
    logic    wmem;
    logic    aluimm;
    logic    shift;
    logic    jal;
    aluc_e   aluc;
    immsel_e immsel;
    logic    use_rs;
    logic    use_rt;
  } ctrl_t;

endpackage

// File: rtl/id_stage_if.sv
// IF/ID -> ID -> ID/EX pipeline bundle; master is the pipeline side that
// feeds ID and consumes ID/EX, slave is the decode stage itself.
interface id_stage_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          d_valid;
  logic [DW-1:0] d_inst;
  logic [DW-1:0] d_pc4;
  logic          flush;
  logic          stall;
  logic          e_valid;
  logic [DW-1:0] e_a;
  logic [DW-1:0] e_b;
  logic [DW-1:0] e_imm;
  logic [DW-1:0] e_pc4;
  logic [AW-1:0] e_wn;
  logic [3:0]    e_aluc;
  logic          e_wreg;
  logic          e_m2reg;
  logic          e_wmem;
  logic          e_aluimm;
  logic          e_shift;
  logic          e_jal;

  modport master (
    output d_valid, d_inst, d_pc4, flush,
    input  stall, e_valid, e_a, e_b, e_imm, e_pc4, e_wn, e_aluc,
           e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_jal
  );

  modport slave (
    input  d_valid, d_inst, d_pc4, flush,
    output stall, e_valid, e_a, e_b, e_imm, e_pc4, e_wn, e_aluc,
           e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_jal
  );
endinterface

// File: rtl/id_stage_ctrl.sv
// Combinational instruction decoder: control bits, operand-usage flags for
// hazard detection, and destination register select.
module id_ctrl
  import uMIPS_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output ctrl_t      ctl,
  output logic [4:0] wn
);

  always_comb begin
    ctl        = '0;
    ctl.aluc   = ALUC_ADD;
    ctl.immsel = IMM_SEXT;
    ctl.use_rs = 1'b1;
    ctl.use_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctl.use_rt = 1'b1;
        case (fn)
          FN_ADD: ctl.wreg = 1'b1;
          FN_SUB: begin ctl.wreg = 1'b1; ctl.aluc = ALUC_SUB; end
          FN_AND: begin ctl.wreg = 1'b1; ctl.aluc = ALUC_AND; end
          FN_OR:  begin ctl.wreg = 1'b1; ctl.aluc = ALUC_OR;  end
          FN_XOR: begin ctl.wreg = 1'b1; ctl.aluc = ALUC_XOR; end
          FN_SLL: begin ctl.wreg = 1'b1; ctl.shift = 1'b1; ctl.use_rs = 1'b0; ctl.aluc = ALUC_SLL; end
          FN_SRL: begin ctl.wreg = 1'b1; ctl.shift = 1'b1; ctl.use_rs = 1'b0; ctl.aluc = ALUC_SRL; end
          FN_SRA: begin ctl.wreg = 1'b1; ctl.shift = 1'b1; ctl.use_rs = 1'b0; ctl.aluc = ALUC_SRA; end
          FN_JR:  ;
          default: ;
        endcase
      end
      OP_ADDI: begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; end
      OP_ANDI: begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; ctl.aluc = ALUC_AND; ctl.immsel = IMM_ZEXT; end
      OP_ORI:  begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; ctl.aluc = ALUC_OR;  ctl.immsel = IMM_ZEXT; end
      OP_XORI: begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; ctl.aluc = ALUC_XOR; ctl.immsel = IMM_ZEXT; end
      OP_LUI: begin
        ctl.wreg = 1'b1; ctl.aluimm = 1'b1; ctl.aluc = ALUC_LUI;
        ctl.immsel = IMM_LUI; ctl.use_rs = 1'b0;
      end
      OP_LW:  begin ctl.wreg = 1'b1; ctl.m2reg = 1'b1; ctl.aluimm = 1'b1; end
      OP_SW:  begin ctl.wmem = 1'b1; ctl.aluimm = 1'b1; ctl.use_rt = 1'b1; end
      OP_BEQ, OP_BNE: begin ctl.aluc = ALUC_SUB; ctl.use_rt = 1'b1; end
      OP_J:   ctl.use_rs = 1'b0;
      OP_JAL: begin ctl.wreg = 1'b1; ctl.jal = 1'b1; ctl.use_rs = 1'b0; end
      default: ;
    endcase

    if (op == OP_RTYPE)    wn = rd;
    else if (op == OP_JAL) wn = REG31;
    else                   wn = rt;
    // Writes to $0 are architecturally discarded; drop them at decode.
    if (wn == '0) ctl.wreg = 1'b0;
  end

endmodule

// File: rtl/id_stage.sv
// uMIPS_32 ID stage: decode, regfile read, EX/MEM/WB forwarding, load-use
// stall detection and the ID/EX pipeline register.
module id_stage
  import uMIPS_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clrn,
  id_stage_if.slave     id,
  output logic [AW-1:0] rna,
  output logic [AW-1:0] rnb,
  input  logic [DW-1:0] qa,
  input  logic [DW-1:0] qb,
  input  logic [AW-1:0] ex_wn,
  input  logic          ex_wreg,
  input  logic          ex_m2reg,
  input  logic [DW-1:0] ex_res,
  input  logic [AW-1:0] mem_wn,
  input  logic          mem_wreg,
  input  logic [DW-1:0] mem_res,
  input  logic [AW-1:0] wb_wn,
  input  logic          wb_we,
  input  logic [DW-1:0] wb_d
);

  logic [AW-1:0] rs, rt;
  logic [15:0]   imm16;
  ctrl_t         ctl;
  logic [4:0]    dwn;
  logic [DW-1:0] fa, fb, opa, immx;

  assign rs    = id.d_inst[25:21];
  assign rt    = id.d_inst[20:16];
  assign imm16 = id.d_inst[15:0];
  assign rna   = rs;
  assign rnb   = rt;

  id_ctrl u_ctrl (
    .op  (id.d_inst[31:26]),
    .fn  (id.d_inst[5:0]),
    .rt  (id.d_inst[20:16]),
    .rd  (id.d_inst[15:11]),
    .ctl (ctl),
    .wn  (dwn)
  );

  // A load in EX is excluded from forwarding; its value only exists from MEM on.
  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] r, input logic [DW-1:0] q);
    logic [DW-1:0] v;
    if (r == '0)                                  v = '0;
    else if (ex_wreg && !ex_m2reg && ex_wn == r)  v = ex_res;
    else if (mem_wreg && mem_wn == r)             v = mem_res;
    else if (wb_we && wb_wn == r)                 v = wb_d;
    else                                          v = q;
    return v;
  endfunction

  always_comb begin
    fa  = fwd(rs, qa);
    fb  = fwd(rt, qb);
    opa = ctl.shift ? {{(DW-5){1'b0}}, id.d_inst[10:6]} : fa;
    case (ctl.immsel)
      IMM_ZEXT: immx = {{(DW-16){1'b0}}, imm16};
      IMM_LUI:  immx = {imm16, {(DW-16){1'b0}}};
      default:  immx = {{(DW-16){imm16[15]}}, imm16};
    endcase
  end

  assign id.stall = id.d_valid && ex_wreg && ex_m2reg && (ex_wn != '0) &&
                    ((ctl.use_rs && ex_wn == rs) || (ctl.use_rt && ex_wn == rt));

  // Bubbles clear only control; datapath fields keep their last values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      id.e_valid  <= 1'b0;
      id.e_a      <= '0;
      id.e_b      <= '0;
      id.e_imm    <= '0;
      id.e_pc4    <= '0;
      id.e_wn     <= '0;
      id.e_aluc   <= '0;
      id.e_wreg   <= 1'b0;
      id.e_m2reg  <= 1'b0;
      id.e_wmem   <= 1'b0;
      id.e_aluimm <= 1'b0;
      id.e_shift  <= 1'b0;
      id.e_jal    <= 1'b0;
    end else if (id.flush || id.stall || !id.d_valid) begin
      id.e_valid  <= 1'b0;
      id.e_aluc   <= '0;
      id.e_wreg   <= 1'b0;
      id.e_m2reg  <= 1'b0;
      id.e_wmem   <= 1'b0;
      id.e_aluimm <= 1'b0;
      id.e_shift  <= 1'b0;
      id.e_jal    <= 1'b0;
    end else begin
      id.e_valid  <= 1'b1;
      id.e_a      <= opa;
      id.e_b      <= fb;
      id.e_imm    <= immx;
      id.e_pc4    <= id.d_pc4;
      id.e_wn     <= dwn;
      id.e_aluc   <= ctl.aluc;
      id.e_wreg   <= ctl.wreg;
      id.e_m2reg  <= ctl.m2reg;
      id.e_wmem   <= ctl.wmem;
      id.e_aluimm <= ctl.aluimm;
      id.e_shift  <= ctl.shift;
      id.e_jal    <= ctl.jal;
    end
  end

endmodule
